// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow, asynchronous divided clock in clk_in cycles,
// and tracks whether the measured period has settled within tolerance of EXPECT_DIV.
module clk_period_meter #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned EXPECT_DIV = 4,
  parameter int unsigned TOL        = 0,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int unsigned LoBound = (EXPECT_DIV > TOL) ? EXPECT_DIV - TOL : 0;
  localparam int unsigned HiBound = EXPECT_DIV + TOL;
  localparam int unsigned StreakW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]   CntMax     = '1;
  localparam logic [StreakW-1:0] StreakFull = StreakW'(LOCK_COUNT);

  typedef enum logic {StIdle, StMeas} state_e;

  state_e             state_q, state_d;
  logic               s1_q, s2_q, s3_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   hi_q, hi_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   high_q, high_d;
  logic               locked_q, locked_d;
  logic               mv_q, mv_d;
  logic               to_q, to_d;
  logic               rise, fall, in_tol;

  // s1/s2 synchronize; s3 is the delayed copy used for edge detection
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise   = s2_q & ~s3_q;
  assign fall   = ~s2_q & s3_q;
  assign in_tol = (64'(cnt_q) >= 64'(LoBound)) && (64'(cnt_q) <= 64'(HiBound));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    streak_d = streak_q;
    period_d = period_q;
    high_d   = high_q;
    locked_d = locked_q;
    mv_d     = 1'b0;
    to_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StMeas;
          cnt_d   = CNT_W'(1);
        end
      end
      StMeas: begin
        if (rise) begin
          period_d = cnt_q;
          high_d   = hi_q;
          mv_d     = 1'b1;
          cnt_d    = CNT_W'(1);
          if (in_tol) begin
            streak_d = (streak_q == StreakFull) ? streak_q : streak_q + StreakW'(1);
          end else begin
            streak_d = '0;
          end
          locked_d = (streak_d == StreakFull);
        end else begin
          if (fall) hi_d = cnt_q;
          if (cnt_q == CntMax) begin
            to_d     = 1'b1;
            state_d  = StIdle;
            streak_d = '0;
            locked_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      streak_q <= '0;
      period_q <= '0;
      high_q   <= '0;
      locked_q <= 1'b0;
      mv_q     <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      streak_q <= streak_d;
      period_q <= period_d;
      high_q   <= high_d;
      locked_q <= locked_d;
      mv_q     <= mv_d;
      to_q     <= to_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = mv_q;
  assign locked     = locked_q;
  assign timeout    = to_q;

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the period and high time of a slow divided clock, counted in `clk_in` cycles, and flags whether it matches an expected divide ratio. It sits downstream of the clock divider as its reader: it samples the divided clock as asynchronous data, reports every completed period, and raises `locked` once the ratio has been stable for a programmable number of periods. Used for bring-up checks and run-time divider health monitoring.

## Interface
- `CNT_W`, 16, width of the cycle counter and of the `period`/`high_time` outputs
- `EXPECT_DIV`, 4, expected period in `clk_in` cycles
- `TOL`, 0, allowed absolute deviation from `EXPECT_DIV`, in cycles
- `LOCK_COUNT`, 4, consecutive in-tolerance periods required to assert `locked` (≥1)
- `clk_in`  in  1  single system clock; all logic on its rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted when 0)
- `sig_in`  in  1  divided clock under measurement; asynchronous to `clk_in`
- `period`  out  CNT_W  last completed period (rise-to-rise), in `clk_in` cycles
- `high_time`  out  CNT_W  high-phase length of that same period, in cycles
- `meas_valid`  out  1  one-cycle pulse when `period`/`high_time` update
- `locked`  out  1  ratio stable and within tolerance
- `timeout`  out  1  one-cycle pulse when the counter saturates with no rising edge

## Operation
- `sig_in` passes through a 2-flop synchronizer (s1, s2), then a third flop s3.
- Rise is detected when s2=1 and s3=0; fall is detected when s2=0 and s3=1.
- The FSM has two states:
  - IDLE: waiting for the first rise. On a rise, go to MEAS and load cnt=1. No `meas_valid` is generated.
  - MEAS: cnt increments by 1 every cycle.
    - On a fall, `hi_cnt` ← cnt.
    - On a rise, `period` ← cnt, `high_time` ← `hi_cnt`, `meas_valid`=1, then cnt reloads to 1.
- Saturation: if cnt reaches 2^CNT_W−1 in MEAS with no rise:
  - pulse `timeout`, go to IDLE;
  - clear `locked` and the streak counter;
  - `period`/`high_time` hold their last values.
- Tolerance check on each `meas_valid`: a period is in tolerance when |`period` − `EXPECT_DIV`| ≤ `TOL`. Use unsigned compare against `EXPECT_DIV`−`TOL` and `EXPECT_DIV`+`TOL`; the lower bound clamps at 0.
- Lock tracking:
  - In tolerance: the streak increments, saturating at `LOCK_COUNT`. `locked`=1 when the streak equals `LOCK_COUNT`.
  - Out of tolerance: the streak is cleared to 0 and `locked`=0 on the same update.
- Simultaneous rise and fall cannot occur, since s2/s3 are mutually exclusive per cycle.
- If no fall was seen since the last rise, `high_time` reports the previous `hi_cnt`. This case is not flagged.

## Timing
- Reset values (asserted asynchronously, released synchronously to `clk_in`):
  - FSM=IDLE; s1/s2/s3=0; cnt=0; `hi_cnt`=0; streak=0.
  - `period`=0, `high_time`=0, `meas_valid`=0, `locked`=0, `timeout`=0.
- Detection latency: 2–3 `clk_in` edges from a `sig_in` transition to detection, depending on sampling phase. Registered outputs update on the edge after detection.
- `meas_valid` and `timeout` are exactly one cycle wide and are never asserted together.
- `locked` changes only in the cycle `meas_valid` asserts, or on `timeout`.
- Reset mid-measurement discards the partial count. The next first rise after reset produces no `meas_valid`.
- For an ideal divide-by-N input, N ≥ 2: `period`=N exactly, and `high_time`=N/2 for an even-N 50 % duty divider.

## Test plan
- Divide-by-4 input, 1 kHz `clk_in`, defaults → first `meas_valid` at the second rise with `period`=4, `high_time`=2; `locked`=1 in the cycle of the 4th `meas_valid`.
- Switch the input from divide-by-4 to divide-by-6 while locked → next `meas_valid` reports `period`=6 and `locked` drops to 0 in that cycle; with `EXPECT_DIV`=6 it re-locks after 4 periods.
- `TOL`=1, `EXPECT_DIV`=4, input alternating periods 3 and 5 → every measurement in tolerance, `locked`=1 after 4; a period of 6 clears it.
- `CNT_W`=8, `sig_in` stuck low after lock → `timeout` pulses once, 255 cycles after the last rise reload; `locked`=0; FSM returns to IDLE; the next two rises give one `meas_valid`.
- Assert `rst`=0 for 3 cycles mid-period while locked → all outputs read 0 immediately; after release, no `meas_valid` at the first rise; the correct `period` appears at the second rise.
- Asynchronous jitter: `sig_in` edges placed at random sub-cycle offsets for divide-by-8 → `period` always within 7..9 and `locked` held with `TOL`=1.
